// File: rtl/trig_thresh_servo.sv
// Round-robin threshold servo: per tick, sweeps all channels, compares
// scaler counts to a target and nudges thresholds, writing changes over WB.
//
// Ports:
//   clk_i, rst_i                   clock, sync active-high reset
//   enable_i, tick_i               servo enable, sweep start strobe
//   target_i, deadband_i, step_i   servo tuning
//   load_i, load_chan_i, load_val_i  software threshold load
//   scal_req_o, scal_chan_o        scaler count request
//   scal_valid_i, scal_count_i     scaler count response
//   pwm_*                          Wishbone master to PWM threshold space
//   busy_o, done_o, overrun_o, err_o  status
module trig_thresh_servo #(
  parameter int NCHAN       = 24,
  parameter int THRESH_BITS = 16,
  parameter int SCALER_BITS = 16,
  parameter logic [THRESH_BITS-1:0] INIT_THRESH = 16'h8000,
  parameter logic [THRESH_BITS-1:0] MIN_THRESH  = 16'h0000,
  parameter logic [THRESH_BITS-1:0] MAX_THRESH  = 16'hFFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   tick_i,
  input  logic [SCALER_BITS-1:0] target_i,
  input  logic [7:0]             deadband_i,
  input  logic [7:0]             step_i,
  input  logic                   load_i,
  input  logic [4:0]             load_chan_i,
  input  logic [THRESH_BITS-1:0] load_val_i,
  output logic                   scal_req_o,
  output logic [4:0]             scal_chan_o,
  input  logic                   scal_valid_i,
  input  logic [SCALER_BITS-1:0] scal_count_i,
  output logic                   pwm_cyc_o,
  output logic                   pwm_stb_o,
  output logic                   pwm_we_o,
  output logic [8:0]             pwm_adr_o,
  output logic [31:0]            pwm_dat_o,
  input  logic                   pwm_ack_i,
  input  logic                   pwm_err_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o,
  output logic                   err_o
);

  localparam int CW  = SCALER_BITS + 9;
  localparam int TW1 = THRESH_BITS + 1;
  localparam logic [4:0] LAST = 5'(NCHAN - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, CALC, WRITE, NEXT
  } state_t;

  state_t state_q, state_d;

  logic [4:0]             chan_q;
  logic [SCALER_BITS-1:0] count_q;
  logic [THRESH_BITS-1:0] new_q;
  logic                   err_q;
  logic                   done_q;
  logic                   ovr_q;
  logic [THRESH_BITS-1:0] thr_q [NCHAN];

  logic [CW-1:0]          cnt_x, tgt_x, db_x;
  logic                   up_c, dn_c;
  logic [THRESH_BITS-1:0] thr_cur, new_c;
  logic [TW1-1:0]         sum_c, floor_c;

  // Adjustment math, widened so target+deadband cannot wrap.
  always_comb begin
    cnt_x   = CW'(count_q);
    tgt_x   = CW'(target_i);
    db_x    = CW'(deadband_i);
    up_c    = cnt_x > (tgt_x + db_x);
    dn_c    = (cnt_x + db_x) < tgt_x;
    thr_cur = thr_q[chan_q];
    sum_c   = TW1'(thr_cur) + TW1'(step_i);
    floor_c = TW1'(MIN_THRESH) + TW1'(step_i);
    new_c   = thr_cur;
    if (up_c) begin
      if (sum_c > TW1'(MAX_THRESH))
        new_c = MAX_THRESH;
      else
        new_c = sum_c[THRESH_BITS-1:0];
    end else if (dn_c) begin
      if (TW1'(thr_cur) < floor_c)
        new_c = MIN_THRESH;
      else
        new_c = thr_cur - THRESH_BITS'(step_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tick_i && enable_i) state_d = REQ;
      REQ:   if (scal_valid_i) state_d = CALC;
      CALC:  state_d = (new_c == thr_cur) ? NEXT : WRITE;
      WRITE: if (pwm_ack_i || pwm_err_i) state_d = NEXT;
      NEXT: begin
        if (chan_q == LAST)  state_d = IDLE;
        else if (enable_i)   state_d = REQ;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chan_q  <= '0;
      count_q <= '0;
      new_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NCHAN; i++)
        thr_q[i] <= INIT_THRESH;
    end else begin
      done_q <= (state_q == NEXT) && (chan_q == LAST);
      ovr_q  <= tick_i && (state_q != IDLE);
      if (state_q == IDLE && tick_i && enable_i) begin
        chan_q <= '0;
        err_q  <= 1'b0;
      end
      if (state_q == REQ && scal_valid_i)
        count_q <= scal_count_i;
      if (state_q == CALC) begin
        new_q <= new_c;
        if (new_c != thr_cur)
          thr_q[chan_q] <= new_c;
      end
      if (state_q == WRITE && pwm_err_i)
        err_q <= 1'b1;
      if (state_q == NEXT && chan_q != LAST)
        chan_q <= chan_q + 5'd1;
      // Placed last so a same-cycle load overrides the CALC update.
      if (load_i && (32'(load_chan_i) < NCHAN))
        thr_q[load_chan_i] <= load_val_i;
    end
  end

  always_comb begin
    scal_req_o  = (state_q == REQ);
    scal_chan_o = (state_q == REQ) ? chan_q : 5'd0;
    pwm_cyc_o   = (state_q == WRITE);
    pwm_stb_o   = (state_q == WRITE);
    pwm_we_o    = (state_q == WRITE);
    pwm_adr_o   = (state_q == WRITE) ? {2'b00, chan_q, 2'b00} : 9'd0;
    pwm_dat_o   = (state_q == WRITE) ? 32'(new_q) : 32'd0;
    busy_o      = (state_q != IDLE);
    done_o      = done_q;
    overrun_o   = ovr_q;
    err_o       = err_q;
  end

endmodule

// File: doc/trig_thresh_servo.md
Name: trig_thresh_servo

Overview:
- Round-robin threshold servo for the 24 trigger-comparator channels.
- On each servo tick, walks channels 0..NCHAN-1. For each channel it requests a scaler count, compares it to a target rate, and nudges that channel's threshold by a fixed step.
- Writes each changed threshold into the PWM threshold space as a Wishbone master.
- Sits beside the trigger top-level, driving the PWM core's slave port through an arbiter shared with software.

Parameters:
- NCHAN, 24, number of channels serviced; channel index width is 5 bits.
- THRESH_BITS, 16, width of the threshold value.
- SCALER_BITS, 16, width of the scaler count.
- INIT_THRESH, 16'h8000, reset value of every stored threshold.
- MIN_THRESH, 16'h0000, lower saturation limit.
- MAX_THRESH, 16'hFFFF, upper saturation limit.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  servo enable.
- tick_i  in  1  one-cycle strobe that starts a sweep.
- target_i  in  SCALER_BITS  target count per channel.
- deadband_i  in  8  no-adjust band, ± counts.
- step_i  in  8  threshold increment per adjustment.
- load_i  in  1  software threshold load strobe.
- load_chan_i  in  5  channel being loaded.
- load_val_i  in  THRESH_BITS  value being loaded.
- scal_req_o  out  1  scaler count request.
- scal_chan_o  out  5  channel whose count is requested.
- scal_valid_i  in  1  scaler count valid.
- scal_count_i  in  SCALER_BITS  scaler count.
- pwm_cyc_o, pwm_stb_o, pwm_we_o  out  1 each  Wishbone master control.
- pwm_adr_o  out  9  PWM word address.
- pwm_dat_o  out  32  write data.
- pwm_ack_i, pwm_err_i  in  1 each  Wishbone slave response.
- busy_o  out  1  high while not IDLE.
- done_o  out  1  one-cycle pulse at sweep end.
- overrun_o  out  1  one-cycle pulse when a tick is dropped.
- err_o  out  1  sticky bus-error flag.

Behaviour:
- Reset:
  - all outputs 0; FSM to IDLE; channel counter 0.
  - all NCHAN stored thresholds set to INIT_THRESH.
  - err_o cleared.
- IDLE:
  - tick_i && enable_i -> REQ, with chan=0 and err_o cleared.
  - tick_i while busy_o=1 is ignored and pulses overrun_o for one cycle.
- REQ:
  - scal_req_o=1 and scal_chan_o=chan, held until scal_valid_i.
  - On the valid cycle, latch scal_count_i, drop scal_req_o next cycle, go to CALC.
- CALC (1 cycle), all comparisons in SCALER_BITS+9 bits so no overflow:
  - count > target+deadband: new = min(thr+step, MAX_THRESH).
  - count+deadband < target: new = thr-step, floored at MIN_THRESH with no underflow wrap.
  - otherwise new = thr.
  - If new == thr, skip WRITE and go to NEXT; else store new and go to WRITE.
- WRITE:
  - Assert cyc, stb and we together; pwm_adr_o = {2'b00, chan, 2'b00}; pwm_dat_o = {16'h0, new}.
  - Hold all of these until pwm_ack_i or pwm_err_i; deassert the cycle after.
  - err sets err_o; the stored threshold keeps the new value.
- NEXT:
  - chan == NCHAN-1 -> IDLE with done_o pulse.
  - otherwise chan+1 -> REQ if enable_i, else IDLE (no done_o).
  - enable_i deasserting mid-channel never aborts a pending REQ or WRITE.
- Load:
  - load_i writes the stored threshold at any time; no bus write is issued.
  - If it hits the channel being written back from CALC in the same cycle, the load wins.
  - load_chan_i >= NCHAN is ignored.
- Latency:
  - Channel with change: tick -> first scal_req_o 1 cycle; valid -> stb 2 cycles.
  - Channel without change: NEXT -> REQ 1 cycle.

Test Plan:
- Reset, then tick with enable=1, target=100, deadband=5, step=16, all counts 200 -> 24 writes; addresses 0x000, 0x004 … 0x05C; data 0x8010; done_o after the last ack; busy_o low thereafter.
- Counts=100 on all channels -> 24 scaler requests, zero Wishbone cycles, done_o pulses; counts 96 or 104 (inside the deadband) likewise give no writes.
- load chan 3 = 0xFFF8, step=16, count=0xFFFF, target=0 -> chan 3 writes 0xFFFF (saturated); load 0x0005 with count=0 and target=1000 -> writes 0x0000.
- tick during an active sweep -> overrun_o single pulse, sweep unaffected; stall ack 10 cycles -> cyc, stb, adr and dat held stable for all 10.
- pwm_err_i on chan 7 -> err_o=1, sweep continues to chan 23 and done_o; err_o clears on the next sweep start.
- Drop enable_i during chan 5 WRITE -> the write completes, returns to IDLE with no done_o; rst_i asserted mid-REQ -> next cycle all outputs 0 and thresholds back to 0x8000.
